speck_frame_tx: RTL
===================

# speck_frame_tx

Frame serializer that sits directly upstream of the byte-level UART transmitter in the Speck UART system. It accepts one complete cipher block (default 64-bit Speck ciphertext) per handshake. It emits the block to the UART transmitter one byte at a time: an optional header byte, then the block bytes MSB-first, then an optional XOR checksum. Each byte is paced by the transmitter's busy flag, and a re-issue watchdog covers a lost start pulse.

## Interface
- BLOCK_BYTES, 8, bytes per input block (≥1)
- HEADER_EN, 1, 1 = prepend HEADER_BYTE to each frame
- HEADER_BYTE, 8'hA5, header value
- CKSUM_EN, 1, 1 = append XOR of the data bytes (header excluded)
- ACK_TIMEOUT, 15, cycles to wait for tx_busy to rise before re-issuing (≥2)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- blk_in  input  BLOCK_BYTES*8  block to send; byte 0 = blk_in[MSB-:8]
- blk_valid  input  1  block available
- blk_ready  output  1  serializer can accept; transfer when blk_valid && blk_ready at posedge
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  one-cycle start pulse to UART transmitter
- tx_busy  input  1  UART transmitter busy flag (registered; rises 1 cycle after its start pulse)
- active  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last byte completes
- retry  output  1  one-cycle pulse when the watchdog re-issues a byte

## Operation
- Frame length N = HEADER_EN + BLOCK_BYTES + CKSUM_EN. Byte counter width is clog2(N+1).
- On accept: register blk_in and the checksum (XOR-reduce of all BLOCK_BYTES bytes). Byte index is 0.
- Byte order: HEADER_BYTE (if enabled), blk_in bytes from most significant to least, checksum (if enabled).
- States:
  - IDLE: blk_ready=1. On accept go to ISSUE.
  - ISSUE: drive tx_data = current byte, tx_valid=1 for exactly this cycle. Clear the watchdog. Go to WAIT_ACK.
  - WAIT_ACK:
    - tx_busy=1 → WAIT_DONE.
    - Otherwise increment the watchdog. At ACK_TIMEOUT cycles, pulse retry and go to ISSUE with the same byte.
  - WAIT_DONE: tx_busy=0 → if this was the last byte, go to FINISH; else increment the index and go to ISSUE.
  - FINISH: frame_done=1 for one cycle, then go to IDLE.
- blk_ready = (state==IDLE), combinational from state. No block is accepted mid-frame; blk_valid held high simply waits.
- tx_data holds its value from ISSUE until the next ISSUE. The transmitter samples only on tx_valid.
- tx_busy high while in IDLE or FINISH is ignored.
- Retries are unbounded; the watchdog restarts on every ISSUE.

## Timing
- Reset values: state IDLE, blk_ready=1, tx_valid=0, tx_data=8'h00, active=0, frame_done=0, retry=0; watchdog and index cleared.
- Reset mid-frame aborts immediately. No further tx_valid is issued, and the next accepted block starts from the header.
- Accept at edge E → tx_valid high in the cycle after E (1-cycle latency).
- Inter-byte gap: busy falls at edge F → next tx_valid in cycle after F. The transmitter is back in its idle state at F, so the pulse is never lost.
- active is high from the cycle after accept through FINISH inclusive.
- frame_done is asserted in the cycle after busy falls on the last byte. blk_ready rises in the following cycle.
- Back-to-back frames: minimum gap of 2 cycles (FINISH, IDLE) between the last busy fall and the next frame's first tx_valid.

## Test plan
Bench uses a behavioral UART model: busy rises 1 cycle after tx_valid and stays high 10 cycles.
1. Defaults, blk_in=64'h0123456789ABCDEF → tx_valid sequence carries A5,01,23,45,67,89,AB,CD,EF,00. frame_done pulses once. active low afterwards. retry never asserted.
2. blk_in=64'h00000000000000FF → checksum byte FF. Then blk_valid held high with a second block, 64'h1111111111111111 → second block is not accepted until blk_ready. Second frame = A5, eight 11s, 00.
3. Model ignores the first tx_valid of byte 3 → tx_busy stays low. After 15 WAIT_ACK cycles, retry pulses and tx_valid re-issues with data 45. The frame then completes normally with 10 bytes total accepted by the model.
4. HEADER_EN=0, CKSUM_EN=0, BLOCK_BYTES=4, blk_in=32'hDEADBEEF → exactly DE,AD,BE,EF. frame_done occurs 1 cycle after the 4th busy fall.
5. rst asserted during byte 5 → all outputs reach their reset values asynchronously, including blk_ready=1. After release, new block 64'h0 → frame restarts with A5 and checksum 00.
6. Spurious tx_busy=1 while IDLE → no state change and no tx_valid. The next accepted frame latency is still 1 cycle.

Source files
------------

// File: rtl/speck_frame_tx.sv
// Frame serializer ahead of the UART transmitter: sends optional header, block bytes MSB-first and
// an optional XOR checksum, one byte per transmitter busy cycle, re-issuing a byte if busy never rises.
module speck_frame_tx #(
  parameter int         BLOCK_BYTES = 8,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         CKSUM_EN    = 1,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BLOCK_BYTES*8-1:0] blk_in,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_busy,
  output logic                     active,
  output logic                     frame_done,
  output logic                     retry
);

  localparam int FRAME_LEN = HEADER_EN + BLOCK_BYTES + CKSUM_EN;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int WD_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic [BLOCK_BYTES*8-1:0] blk_q, blk_d;
  logic [7:0]               cksum_q, cksum_d;
  logic [CNT_W-1:0]         idx_q, idx_d;
  logic [WD_W-1:0]          wdog_q, wdog_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic [7:0]               blk_xor;
  logic [7:0]               cur_byte;

  always_comb begin
    blk_xor = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      blk_xor = blk_xor ^ blk_in[i*8 +: 8];
    end
  end

  // Byte index maps to header, then block bytes MSB-first, with the checksum as the fall-through.
  always_comb begin
    cur_byte = cksum_q;
    if (HEADER_EN != 0 && idx_q == '0) begin
      cur_byte = HEADER_BYTE;
    end
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (idx_q == CNT_W'(i + HEADER_EN)) begin
        cur_byte = blk_q[(BLOCK_BYTES-1-i)*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    cksum_d    = cksum_q;
    idx_d      = idx_q;
    wdog_d     = wdog_q;
    tx_data_d  = tx_data_q;
    blk_ready  = 1'b0;
    tx_valid   = 1'b0;
    retry      = 1'b0;
    frame_done = 1'b0;
    active     = (state_q != IDLE);
    tx_data    = tx_data_q;
    unique case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          blk_d   = blk_in;
          cksum_d = blk_xor;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tx_valid  = 1'b1;
        tx_data   = cur_byte;
        tx_data_d = cur_byte;
        wdog_d    = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wdog_q == WD_LAST) begin
          retry   = 1'b1;
          state_d = ISSUE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      cksum_q   <= '0;
      idx_q     <= '0;
      wdog_q    <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      cksum_q   <= cksum_d;
      idx_q     <= idx_d;
      wdog_q    <= wdog_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule
